cla_mp_sequencer: RTL and testbench

//  Multi-precision add/subtract controller built around one CLA_32 instance.

---
 rtl/cla_mp_sequencer.sv | 157 +++++++++++++++
 tb/tb_cla_mp_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: a WORDS*32-bit A+B or A-B is computed
// one 32-bit slice per cycle, least significant first, on a single 32-bit CLA,
// with the inter-slice carry kept in a register.
// Optional feature macro: CLA_SEQ_SAT_EN (signed saturation of the final result).

module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out,
  output logic        overflow
);
  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;

  // 4-bit lookahead groups; the group carry-out ripples into the next group
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = c_in;
    for (int k = 0; k < 32; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k]) | ((&p[k +: 4]) & c[k]);
    end
    s        = p ^ c[31:0];
    c_out    = c[32];
    overflow = c[32] ^ c[31];
  end
endmodule

module cla_mp_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  op_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   result,
  output logic                  carry_out,
  output logic                  overflow
);
  localparam int unsigned W     = 32 * WORDS;
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             sub_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [31:0]      slice_a;
  logic [31:0]      slice_b;
  logic [31:0]      slice_s;
  logic             slice_c;
  logic             slice_ovf;
  logic             accept;
  logic             last;

  assign accept = in_valid & in_ready;
  assign last   = (state_q == RUN) && (idx_q == IDX_LAST);

  // Current slice operands; B is inverted for subtract, +1 comes from carry_q
  always_comb begin
    slice_a = a_q[{idx_q, 5'd0} +: 32];
    slice_b = b_q[{idx_q, 5'd0} +: 32] ^ {32{sub_q}};
  end

  cla_32 u_cla (
    .a        (slice_a),
    .b        (slice_b),
    .c_in     (carry_q),
    .s        (slice_s),
    .c_out    (slice_c),
    .overflow (slice_ovf)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake outputs decoded from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Operand capture, per-slice result write and carry chaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= op_sub;
            idx_q   <= '0;
            carry_q <= op_sub;
          end
        end
        RUN: begin
          result[{idx_q, 5'd0} +: 32] <= slice_s;
          carry_q <= slice_c;
          if (last) begin
            carry_out <= slice_c;
            overflow  <= slice_ovf;
`ifdef CLA_SEQ_SAT_EN
            // Clamp toward the sign of A when the full-width result overflowed
            if (slice_ovf) result <= {a_q[W-1], {(W-1){~a_q[W-1]}}};
`endif
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Self-checking bench for cla_mp_sequencer at WORDS=4, 2 and 16.
module tb_cla_mp_sequencer;
  typedef struct {
    logic [511:0] r;
    logic         c;
    logic         v;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic         iv4 = 1'b0, sub4 = 1'b0, ordy4 = 1'b1;
  logic         ir4, ov4, co4, vf4;
  logic [127:0] a4 = '0, b4 = '0, r4;
  logic         iv2 = 1'b0, sub2 = 1'b0, ordy2 = 1'b1;
  logic         ir2, ov2, co2, vf2;
  logic [63:0]  a2 = '0, b2 = '0, r2;
  logic         iv16 = 1'b0, sub16 = 1'b0, ordy16 = 1'b1;
  logic         ir16, ov16, co16, vf16;
  logic [511:0] a16 = '0, b16 = '0, r16;

  exp_t q4[$];
  exp_t q2[$];
  exp_t q16[$];

  cla_mp_sequencer #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op_a(a4), .op_b(b4),
    .op_sub(sub4), .out_valid(ov4), .out_ready(ordy4), .result(r4), .carry_out(co4),
    .overflow(vf4));
  cla_mp_sequencer #(.WORDS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op_a(a2), .op_b(b2),
    .op_sub(sub2), .out_valid(ov2), .out_ready(ordy2), .result(r2), .carry_out(co2),
    .overflow(vf2));
  cla_mp_sequencer #(.WORDS(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op_a(a16), .op_b(b16),
    .op_sub(sub16), .out_valid(ov16), .out_ready(ordy16), .result(r16), .carry_out(co16),
    .overflow(vf16));

  // Golden full-width A+B / A-B with carry and signed overflow
  function automatic exp_t golden(input logic [511:0] a, input logic [511:0] b,
                                  input logic sub, input int w);
    logic [511:0] mask;
    logic [511:0] am;
    logic [511:0] bb;
    logic [512:0] t;
    exp_t e;
    mask = (w == 512) ? '1 : ((512'(1) << w) - 512'(1));
    am   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    t    = {1'b0, am} + {1'b0, bb} + 513'(sub);
    e.r  = t[511:0] & mask;
    e.c  = t[w];
    e.v  = (am[w-1] == bb[w-1]) && (e.r[w-1] != am[w-1]);
`ifdef CLA_SEQ_SAT_EN
    if (e.v) e.r = am[w-1] ? (512'(1) << (w - 1)) : (mask >> 1);
`endif
    return e;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] x;
    for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction

  // Scoreboard, WORDS=4
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q4.delete();
    else begin
      if (iv4 && ir4) q4.push_back(golden({384'b0, a4}, {384'b0, b4}, sub4, 128));
      if (ov4 && ordy4) begin
        vectors++;
        if (q4.size() == 0) begin
          miscompares++;
          $display("FAIL sb4 unexpected out_valid result=%h", r4);
        end else begin
          e = q4.pop_front();
          if (r4 !== e.r[127:0] || co4 !== e.c || vf4 !== e.v) begin
            miscompares++;
            $display("FAIL sb4 got %h c=%b v=%b required %h c=%b v=%b",
                     r4, co4, vf4, e.r[127:0], e.c, e.v);
          end
        end
      end
    end
  end

  // Scoreboard, WORDS=2
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q2.delete();
    else begin
      if (iv2 && ir2) q2.push_back(golden({448'b0, a2}, {448'b0, b2}, sub2, 64));
      if (ov2 && ordy2) begin
        vectors++;
        if (q2.size() == 0) begin
          miscompares++;
          $display("FAIL sb2 unexpected out_valid result=%h", r2);
        end else begin
          e = q2.pop_front();
          if (r2 !== e.r[63:0] || co2 !== e.c || vf2 !== e.v) begin
            miscompares++;
            $display("FAIL sb2 got %h c=%b v=%b required %h c=%b v=%b",
                     r2, co2, vf2, e.r[63:0], e.c, e.v);
          end
        end
      end
    end
  end

  // Scoreboard, WORDS=16
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q16.delete();
    else begin
      if (iv16 && ir16) q16.push_back(golden(a16, b16, sub16, 512));
      if (ov16 && ordy16) begin
        vectors++;
        if (q16.size() == 0) begin
          miscompares++;
          $display("FAIL sb16 unexpected out_valid result=%h", r16);
        end else begin
          e = q16.pop_front();
          if (r16 !== e.r || co16 !== e.c || vf16 !== e.v) begin
            miscompares++;
            $display("FAIL sb16 got %h c=%b v=%b required %h c=%b v=%b",
                     r16, co16, vf16, e.r, e.c, e.v);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [127:0] a, input logic [127:0] b, input logic sub);
    a4 = a; b4 = b; sub4 = sub; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
  endtask

  task automatic wait_ov4(output int lat);
    lat = 0;
    while (!ov4 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic set_in(input int which, input logic [511:0] a, input logic [511:0] b,
                        input logic sub, input logic v);
    case (which)
      2:       begin a2 = a[63:0]; b2 = b[63:0]; sub2 = sub; iv2 = v; end
      16:      begin a16 = a; b16 = b; sub16 = sub; iv16 = v; end
      default: begin a4 = a[127:0]; b4 = b[127:0]; sub4 = sub; iv4 = v; end
    endcase
  endtask

  function automatic logic get_ir(input int which);
    return (which == 2) ? ir2 : (which == 16) ? ir16 : ir4;
  endfunction

  function automatic int qsize(input int which);
    return (which == 2) ? q2.size() : (which == 16) ? q16.size() : q4.size();
  endfunction

  task automatic test_reset();
    #12;
    vectors++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || r4 !== '0 || co4 !== 1'b0 || vf4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values in_ready=%b out_valid=%b result=%h c=%b v=%b required 1 0 0 0 0",
               ir4, ov4, r4, co4, vf4);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cross_carry();
    int lat;
    send4(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0);
    wait_ov4(lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL carry_latency got %0d required 4", lat);
    end
    vectors++;
    if (r4 !== 128'h00000001_00000000_00000000_00000000 || co4 !== 1'b0 || vf4 !== 1'b0) begin
      miscompares++;
      $display("FAIL cross_carry got %h c=%b v=%b", r4, co4, vf4);
    end
    tick();
  endtask

  task automatic test_sub_borrow();
    int lat;
    send4(128'd5, 128'd7, 1'b1);
    wait_ov4(lat);
    vectors++;
    if (r4 !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE || co4 !== 1'b0 || vf4 !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_borrow got %h c=%b v=%b lat=%0d", r4, co4, vf4, lat);
    end
    tick();
  endtask

  task automatic test_signed_ovf();
    int lat;
    logic [127:0] exp_r;
`ifdef CLA_SEQ_SAT_EN
    exp_r = 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
`else
    exp_r = 128'h80000000_00000000_00000000_00000000;
`endif
    send4(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0);
    wait_ov4(lat);
    vectors++;
    if (r4 !== exp_r || vf4 !== 1'b1 || co4 !== 1'b0) begin
      miscompares++;
      $display("FAIL signed_ovf got %h c=%b v=%b required %h c=0 v=1", r4, co4, vf4, exp_r);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    exp_t e;
    logic [127:0] a, b;
    a = 128'h89ABCDEF_01234567_FEDCBA98_76543210;
    b = 128'h11111111_22222222_33333333_44444444;
    e = golden({384'b0, a}, {384'b0, b}, 1'b1, 128);
    ordy4 = 1'b0;
    send4(a, b, 1'b1);
    wait_ov4(lat);
    vectors++;
    if (lat !== 4) begin
      miscompares++;
      $display("FAIL bp_latency got %0d required 4", lat);
    end
    for (int i = 0; i < 10; i++) begin
      if (i >= 3 && i <= 5) begin
        a4 = ~a; b4 = ~b; sub4 = 1'b0; iv4 = 1'b1;
      end else begin
        iv4 = 1'b0;
      end
      vectors++;
      if (ov4 !== 1'b1 || ir4 !== 1'b0 || r4 !== e.r[127:0] || co4 !== e.c || vf4 !== e.v) begin
        miscompares++;
        $display("FAIL backpressure cyc=%0d ov=%b ir=%b r=%h c=%b v=%b required 1 0 %h %b %b",
                 i, ov4, ir4, r4, co4, vf4, e.r[127:0], e.c, e.v);
      end
      tick();
    end
    iv4 = 1'b0;
    ordy4 = 1'b1;
    tick();
    vectors++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release ov=%b ir=%b required 0 1", ov4, ir4);
    end
    tick();
    vectors++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_no_accept ov=%b ir=%b required 0 1", ov4, ir4);
    end
  endtask

  task automatic test_reset_mid_run();
    send4(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (ov4 !== 1'b0 || r4 !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run ov=%b r=%h required 0 0", ov4, r4);
    end
    tick();
    tick();
    rst_n = 1'b1;
    vectors++;
    if (ir4 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release in_ready=%b required 1", ir4);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (ov4 !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_out_valid cyc=%0d ov=%b required 0", i, ov4);
      end
    end
  endtask

  task automatic test_random4();
    int lat;
    for (int n = 0; n < 6; n++) begin
      send4(128'(rand512()), 128'(rand512()), 1'($urandom));
      wait_ov4(lat);
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("FAIL random_latency n=%0d got %0d required 4", n, lat);
      end
      tick();
    end
  endtask

  task automatic test_streaming(input int which, input int words);
    int cyc, acc, last_acc, n;
    logic rdy_before;
    acc = 0; cyc = 0; last_acc = -1;
    set_in(which, rand512(), rand512(), 1'($urandom), 1'b1);
    while (acc < 3 && cyc < 200) begin
      rdy_before = get_ir(which);
      tick();
      cyc++;
      if (rdy_before) begin
        if (last_acc >= 0) begin
          vectors++;
          if (cyc - last_acc !== words + 2) begin
            miscompares++;
            $display("FAIL stream_period words=%0d got %0d required %0d",
                     words, cyc - last_acc, words + 2);
          end
        end
        last_acc = cyc;
        acc++;
        set_in(which, rand512(), rand512(), 1'($urandom), acc < 3);
      end
    end
    vectors++;
    if (acc !== 3) begin
      miscompares++;
      $display("FAIL stream_timeout words=%0d accepts=%0d required 3", words, acc);
    end
    set_in(which, '0, '0, 1'b0, 1'b0);
    n = 0;
    while (qsize(which) != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_cross_carry();
    test_sub_borrow();
    test_signed_ovf();
    test_backpressure();
    test_reset_mid_run();
    test_random4();
    test_streaming(4, 4);
    test_streaming(2, 2);
    test_streaming(16, 16);
    vectors++;
    if (q4.size() + q2.size() + q16.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required 0", q4.size() + q2.size() + q16.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
